// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// regfile_wb_pkg : shared defaults and constants for the writeback register file
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NREGS_DEF  = 8;

  localparam logic [2:0] ZERO_REG = 3'd0;
  localparam logic [7:0] CNT_MAX  = 8'd255;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_array.sv
// ============================================================================
// regfile_array : NREGS x DATA_W storage, async reset, one write, two async reads
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_array
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/regfile_wb.sv
// ============================================================================
// regfile_wb : writeback stage register, commit logic, read bypass, commit counter
// Optional: REGFILE_BYPASS_EN forwards the pending stage data to the read ports.
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_in,
  input  logic [ADDR_W-1:0] wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddrA,
  input  logic [ADDR_W-1:0] raddrB,
  output logic [DATA_W-1:0] rdA_out,
  output logic [DATA_W-1:0] rdB_out,
  output logic              wb_pending,
  output logic [7:0]        commit_cnt
);

  logic              wb_v;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;

  // Writes to register 0 are dropped here so the array entry stays 0 forever.
  assign commit = wb_v && !stall && !flush && (wb_addr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_v       <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      commit_cnt <= '0;
    end else begin
      if (flush) begin
        wb_v <= 1'b0;
      end else if (!stall) begin
        wb_v    <= wb_valid_in;
        wb_addr <= wb_addr_in;
        wb_data <= wb_data_in;
      end
      if (commit && (commit_cnt != CNT_MAX)) begin
        commit_cnt <= commit_cnt + 8'd1;
      end
    end
  end

  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (raddrA),
    .raddr_b (raddrB),
    .rdata_a (arr_a),
    .rdata_b (arr_b)
  );

  always_comb begin
    rdA_out = arr_a;
    rdB_out = arr_b;
`ifdef REGFILE_BYPASS_EN
    // The stage register always holds the youngest value for its address.
    if (wb_v && (wb_addr == raddrA)) rdA_out = wb_data;
    if (wb_v && (wb_addr == raddrB)) rdB_out = wb_data;
`endif
    if (raddrA == ADDR_W'(ZERO_REG)) rdA_out = '0;
    if (raddrB == ADDR_W'(ZERO_REG)) rdB_out = '0;
  end

  assign wb_pending = wb_v;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
// ============================================================================
// tb_regfile_wb : vector table, corner sequences and random run against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_valid_in;
  logic [2:0] wb_addr_in;
  logic [7:0] wb_data_in;
  logic       stall;
  logic       flush;
  logic [2:0] raddrA;
  logic [2:0] raddrB;
  logic [7:0] rdA_out;
  logic [7:0] rdB_out;
  logic       wb_pending;
  logic [7:0] commit_cnt;

  int tests  = 0;
  int failed = 0;

  regfile_wb dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid_in (wb_valid_in),
    .wb_addr_in  (wb_addr_in),
    .wb_data_in  (wb_data_in),
    .stall       (stall),
    .flush       (flush),
    .raddrA      (raddrA),
    .raddrB      (raddrB),
    .rdA_out     (rdA_out),
    .rdB_out     (rdB_out),
    .wb_pending  (wb_pending),
    .commit_cnt  (commit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus one pending write slot.
  logic [7:0] m_regs [8];
  logic       m_pv;
  logic [2:0] m_pa;
  logic [7:0] m_pd;
  int         m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pv  = 1'b0;
    m_pa  = 3'd0;
    m_pd  = 8'h00;
    m_cnt = 0;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (m_pv && m_pa == a) return m_pd;
`endif
    return m_regs[a];
  endfunction

  function automatic void m_edge();
    if (m_pv && !stall && !flush && m_pa != 3'd0) begin
      m_regs[m_pa] = m_pd;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (flush) m_pv = 1'b0;
    else if (!stall) begin
      m_pv = wb_valid_in;
      m_pa = wb_addr_in;
      m_pd = wb_data_in;
    end
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    chk("pre_rdA", rdA_out, m_read(raddrA));
    chk("pre_rdB", rdB_out, m_read(raddrB));
    @(posedge clk);
    m_edge();
    #1;
    chk("rdA", rdA_out, m_read(raddrA));
    chk("rdB", rdB_out, m_read(raddrB));
    chk("pending", {7'd0, wb_pending}, {7'd0, m_pv});
    chk("commit_cnt", commit_cnt, 8'(m_cnt));
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d,
                       input logic st, input logic fl, input logic [2:0] ra, input logic [2:0] rb);
    wb_valid_in = v;
    wb_addr_in  = a;
    wb_data_in  = d;
    stall       = st;
    flush       = fl;
    raddrA      = ra;
    raddrB      = rb;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       st;
    logic       fl;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea_byp;
    logic [7:0] ea_nob;
    logic [7:0] eb_byp;
    logic [7:0] eb_nob;
    logic       ep;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea, eb;

    // Expected values are taken after the edge on which the row's inputs are sampled.
    vecs[0]  = '{1'b1, 3'd2, 8'hC3, 1'b0, 1'b0, 3'd2, 3'd2, 8'hC3, 8'h00, 8'hC3, 8'h00, 1'b1, 8'd0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 3'd0, 8'hC3, 8'hC3, 8'h00, 8'h00, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00, 8'hC3, 8'hC3, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 3'd5, 8'h11, 1'b0, 1'b0, 3'd5, 3'd2, 8'h11, 8'h00, 8'hC3, 8'hC3, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 3'd5, 8'h11, 8'h00, 8'h11, 8'h00, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 3'd5, 8'h11, 8'h00, 8'h11, 8'h00, 1'b1, 8'd1};
    vecs[7]  = '{1'b1, 3'd3, 8'hEE, 1'b1, 1'b0, 3'd5, 3'd3, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd5, 3'd2, 8'h11, 8'h11, 8'hC3, 8'hC3, 1'b0, 8'd2};
    vecs[9]  = '{1'b1, 3'd5, 8'h77, 1'b0, 1'b0, 3'd5, 3'd5, 8'h77, 8'h11, 8'h77, 8'h11, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 3'd5, 8'h99, 1'b1, 1'b1, 3'd5, 3'd5, 8'h11, 8'h11, 8'h11, 8'h11, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd5, 3'd4, 8'h11, 8'h11, 8'h00, 8'h00, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 3'd4, 8'h10, 1'b0, 1'b0, 3'd4, 3'd5, 8'h10, 8'h00, 8'h11, 8'h11, 1'b1, 8'd2};
    vecs[13] = '{1'b1, 3'd4, 8'h20, 1'b0, 1'b0, 3'd4, 3'd4, 8'h20, 8'h10, 8'h20, 8'h10, 1'b1, 8'd3};
    vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd4, 3'd2, 8'h20, 8'h20, 8'hC3, 8'hC3, 1'b0, 8'd4};
    vecs[15] = '{1'b1, 3'd6, 8'h66, 1'b0, 1'b1, 3'd6, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd4};
    vecs[16] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd6, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd4};

    // Power-on reset
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd3, 3'd2);
    m_reset();
    #1;
    chk("reset_rdA", rdA_out, 8'h00);
    chk("reset_cnt", commit_cnt, 8'd0);
    chk("reset_pending", {7'd0, wb_pending}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].st, vecs[i].fl, vecs[i].ra, vecs[i].rb);
      step();
`ifdef REGFILE_BYPASS_EN
      ea = vecs[i].ea_byp;
      eb = vecs[i].eb_byp;
`else
      ea = vecs[i].ea_nob;
      eb = vecs[i].eb_nob;
`endif
      chk($sformatf("vec%0d_rdA", i), rdA_out, ea);
      chk($sformatf("vec%0d_rdB", i), rdB_out, eb);
      chk($sformatf("vec%0d_pending", i), {7'd0, wb_pending}, {7'd0, vecs[i].ep});
      chk($sformatf("vec%0d_cnt", i), commit_cnt, vecs[i].ec);
    end

    // Asynchronous reset between edges after a committed write to r3
    drive(1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 3'd3, 3'd4);
    step();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd3, 3'd4);
    step();
    chk("pre_async_rdA", rdA_out, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdA", rdA_out, 8'h00);
    chk("async_rst_rdB", rdB_out, 8'h00);
    chk("async_rst_cnt", commit_cnt, 8'd0);
    chk("async_rst_pending", {7'd0, wb_pending}, 8'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation: 260 commits to r1
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 3'd1, 8'(i), 1'b0, 1'b0, 3'd1, 3'd2);
      step();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd1, 3'd2);
    step();
    chk("sat_cnt", commit_cnt, 8'd255);
    chk("sat_r1", rdA_out, 8'(259));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)), 8'($urandom),
            ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
            3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
